// File: rtl/mpu_bus_pkg.sv
// mpu_bus_pkg: command kinds, bus phases, MPU register map and MEM_WRITE sequencing helpers
// shared by the MPU bus master and its bus-cycle engine.
package mpu_bus_pkg;

    typedef enum logic [1:0] {
        CMD_REG_WRITE = 2'd0,
        CMD_REG_READ  = 2'd1,
        CMD_MEM_WRITE = 2'd2,
        CMD_RSVD      = 2'd3
    } cmd_kind_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD,
        PH_RECOVER
    } bus_phase_t;

    localparam logic [2:0] REG_ADDR_LO  = 3'd0;
    localparam logic [2:0] REG_ADDR_MID = 3'd1;
    localparam logic [2:0] REG_ADDR_HI  = 3'd2;
    localparam logic [2:0] REG_DATA     = 3'd3;

    // Sequence step index doubles as the target register; DATA (3) is never skipped.
    function automatic logic [1:0] next_step(input logic [1:0] from, input logic [2:0] skip);
        return (from == 2'd0 && !skip[0]) ? 2'd0 :
               (from <= 2'd1 && !skip[1]) ? 2'd1 :
               (from <= 2'd2 && !skip[2]) ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [7:0] seq_byte(input logic [1:0] step, input logic [16:0] addr,
                                            input logic [7:0] data);
        return step == 2'd0 ? addr[7:0] :
               step == 2'd1 ? addr[15:8] :
               step == 2'd2 ? {7'd0, addr[16]} : data;
    endfunction

endpackage

// File: rtl/mpu_bus_cycle.sv
// mpu_bus_cycle: timing engine for one MPU register bus cycle (setup/strobe/hold/recover);
// a new cycle may start from IDLE or on the final cycle of the current one.
module mpu_bus_cycle #(
    parameter int SETUP_CYCLES   = 1,
    parameter int STROBE_CYCLES  = 2,
    parameter int HOLD_CYCLES    = 1,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       start,
    input  logic       write,
    input  logic [2:0] regsel,
    input  logic [7:0] wdata,
    output logic       done,
    output logic       sample,
    output logic       cs_n,
    output logic       we_n,
    output logic       data_oe,
    output logic [2:0] regsel_out,
    output logic [7:0] data_out
);
    import mpu_bus_pkg::*;

    bus_phase_t phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d, len;
    logic       write_q, write_d, last, load;
    logic [2:0] regsel_q, regsel_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            phase_q  <= PH_IDLE;
            cnt_q    <= 8'd0;
            write_q  <= 1'b0;
            regsel_q <= 3'd0;
            data_q   <= 8'd0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            regsel_q <= regsel_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        len  = phase_q == PH_SETUP  ? 8'(SETUP_CYCLES) :
               phase_q == PH_STROBE ? 8'(STROBE_CYCLES) :
               phase_q == PH_HOLD   ? 8'(HOLD_CYCLES) : 8'(RECOVER_CYCLES);
        last = phase_q != PH_IDLE && cnt_q == len - 8'd1;
        done = last && (phase_q == PH_RECOVER || (phase_q == PH_HOLD && RECOVER_CYCLES == 0));
        load = start && (phase_q == PH_IDLE || done);
    end

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = (last || phase_q == PH_IDLE) ? 8'd0 : cnt_q + 8'd1;
        write_d  = load ? write : write_q;
        regsel_d = load ? regsel : regsel_q;
        data_d   = load ? wdata : data_q;
        if (phase_q == PH_IDLE)
            phase_d = start ? PH_SETUP : PH_IDLE;
        else if (last)
            phase_d = phase_q == PH_SETUP  ? PH_STROBE :
                      phase_q == PH_STROBE ? PH_HOLD :
                      (phase_q == PH_HOLD && RECOVER_CYCLES > 0) ? PH_RECOVER :
                      start ? PH_SETUP : PH_IDLE;
    end

    always_comb begin
        cs_n       = phase_q != PH_STROBE;
        data_oe    = write_q && (phase_q == PH_SETUP || phase_q == PH_STROBE || phase_q == PH_HOLD);
        we_n       = !data_oe;
        sample     = !write_q && phase_q == PH_STROBE && last;
        regsel_out = regsel_q;
        data_out   = data_q;
    end

endmodule

// File: rtl/mpu_bus_master.sv
// mpu_bus_master: command-driven initiator for the VGA MPU register bus.
// Define MPU_MASTER_ADDR_CACHE_EN to skip address-register writes that match the shadow copy.
module mpu_bus_master #(
    parameter int SETUP_CYCLES   = 1,
    parameter int STROBE_CYCLES  = 2,
    parameter int HOLD_CYCLES    = 1,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  mpu_bus_pkg::cmd_kind_t cmdKind,
    input  logic [2:0]            cmdRegister,
    input  logic [16:0]           cmdAddress,
    input  logic [7:0]            cmdData,
    output logic                  rspValid,
    output logic [7:0]            rspData,
    output logic                  busy,
    output logic                  mpuChipSelect,
    output logic                  mpuWriteEnable,
    output logic [2:0]            mpuRegisterSelect,
    inout  wire  [7:0]            mpuData
);
    import mpu_bus_pkg::*;

    logic        rdy_q, busy_q, busy_d, mem_q, mem_d, rsp_valid_q, rsp_valid_d;
    logic [1:0]  step_q, step_d, first, nxt;
    logic [16:0] addr_q, addr_d, addr_sel;
    logic [7:0]  data_q, data_d, rsp_data_q, rsp_data_d, bus_wdata, bus_data;
    logic [2:0]  bus_reg, skip;
    logic        accept, more, start, bus_write, bus_done, bus_sample, data_oe;

    assign cmdReady = rdy_q && !busy_q;
    assign accept   = cmdReady && cmdValid;
    assign addr_sel = busy_q ? addr_q : cmdAddress;
    assign first    = next_step(2'd0, skip);
    assign nxt      = next_step(step_q + 2'd1, skip);
    assign more     = busy_q && bus_done && mem_q && step_q != 2'd3;

`ifdef MPU_MASTER_ADDR_CACHE_EN
    logic        shadow_vld_q, shadow_vld_d;
    logic [16:0] shadow_q, shadow_d;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            shadow_vld_q <= 1'b0;
            shadow_q     <= 17'd0;
        end else begin
            shadow_vld_q <= shadow_vld_d;
            shadow_q     <= shadow_d;
        end
    end

    // Interface post-increments its address after a DATA write, so the shadow follows.
    always_comb begin
        skip         = {shadow_vld_q && shadow_q[16] == addr_sel[16],
                        shadow_vld_q && shadow_q[15:8] == addr_sel[15:8],
                        shadow_vld_q && shadow_q[7:0] == addr_sel[7:0]};
        shadow_vld_d = shadow_vld_q;
        shadow_d     = shadow_q;
        if (accept && (cmdKind == CMD_REG_WRITE || cmdKind == CMD_REG_READ) && !cmdRegister[2])
            shadow_vld_d = 1'b0;
        else if (busy_q && bus_done && mem_q && step_q == 2'd3) begin
            shadow_vld_d = 1'b1;
            shadow_d     = addr_q + 17'd1;
        end
    end
`else
    assign skip = 3'b000;
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_q       <= 1'b0;
            step_q      <= 2'd0;
            addr_q      <= 17'd0;
            data_q      <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
        end else begin
            rdy_q       <= 1'b1;
            busy_q      <= busy_d;
            mem_q       <= mem_d;
            step_q      <= step_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        busy_d      = busy_q;
        mem_d       = mem_q;
        step_d      = step_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = bus_sample;
        rsp_data_d  = bus_sample ? mpuData : rsp_data_q;
        if (accept && cmdKind != CMD_RSVD) begin
            busy_d = 1'b1;
            mem_d  = cmdKind == CMD_MEM_WRITE;
            step_d = first;
            addr_d = cmdAddress;
            data_d = cmdData;
        end else if (more)
            step_d = nxt;
        else if (busy_q && bus_done)
            busy_d = 1'b0;
    end

    always_comb begin
        start     = 1'b0;
        bus_write = cmdKind != CMD_REG_READ;
        bus_reg   = cmdRegister;
        bus_wdata = cmdData;
        if (accept && cmdKind != CMD_RSVD) begin
            start = 1'b1;
            if (cmdKind == CMD_MEM_WRITE) begin
                bus_reg   = {1'b0, first};
                bus_wdata = seq_byte(first, cmdAddress, cmdData);
            end
        end else if (more) begin
            start     = 1'b1;
            bus_write = 1'b1;
            bus_reg   = {1'b0, nxt};
            bus_wdata = seq_byte(nxt, addr_q, data_q);
        end
    end

    mpu_bus_cycle #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .RECOVER_CYCLES(RECOVER_CYCLES)
    ) u_cycle (
        .clock     (clock),
        .resetN    (resetN),
        .start     (start),
        .write     (bus_write),
        .regsel    (bus_reg),
        .wdata     (bus_wdata),
        .done      (bus_done),
        .sample    (bus_sample),
        .cs_n      (mpuChipSelect),
        .we_n      (mpuWriteEnable),
        .data_oe   (data_oe),
        .regsel_out(mpuRegisterSelect),
        .data_out  (bus_data)
    );

    assign mpuData  = data_oe ? bus_data : 8'bz;
    assign busy     = busy_q;
    assign rspValid = rsp_valid_q;
    assign rspData  = rsp_data_q;

endmodule

// File: tb/tb_mpu_bus_master.sv
// tb_mpu_bus_master: directed bench for mpu_bus_master with an MPU register model on the data bus.
module tb_mpu_bus_master;
    import mpu_bus_pkg::*;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        cmdValid = 1'b0, cmdValid2 = 1'b0, frc = 1'b0;
    cmd_kind_t   cmdKind = CMD_REG_WRITE;
    logic [2:0]  cmdRegister = 3'd0;
    logic [16:0] cmdAddress = 17'd0;
    logic [7:0]  cmdData = 8'd0;
    logic        cmdReady, rspValid, busy, cs, we;
    logic        cmdReady2, rspValid2, busy2, cs2, we2;
    logic [7:0]  rspData, rspData2;
    logic [2:0]  rs, rs2;
    wire  [7:0]  mpuData, mpuData2;
    int          n_cmp = 0, n_bad = 0, rsp_cnt = 0;
    logic [10:0] wq[$];
    logic        cs_prev = 1'b1;

    always #5 clock = ~clock;

    // Register model answers reads with 3C during strobe; frc lets the bench probe for DUT drive.
    assign mpuData = (!cs && we) ? 8'h3C : frc ? 8'h5A : 8'hzz;

    mpu_bus_master u1 (
        .clock(clock), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdKind(cmdKind), .cmdRegister(cmdRegister), .cmdAddress(cmdAddress), .cmdData(cmdData),
        .rspValid(rspValid), .rspData(rspData), .busy(busy), .mpuChipSelect(cs),
        .mpuWriteEnable(we), .mpuRegisterSelect(rs), .mpuData(mpuData)
    );

    mpu_bus_master #(.RECOVER_CYCLES(0)) u2 (
        .clock(clock), .resetN(resetN), .cmdValid(cmdValid2), .cmdReady(cmdReady2),
        .cmdKind(cmdKind), .cmdRegister(cmdRegister), .cmdAddress(cmdAddress), .cmdData(cmdData),
        .rspValid(rspValid2), .rspData(rspData2), .busy(busy2), .mpuChipSelect(cs2),
        .mpuWriteEnable(we2), .mpuRegisterSelect(rs2), .mpuData(mpuData2)
    );

    always @(negedge clock) begin
        if (!cs && cs_prev && !we) wq.push_back({rs, mpuData});
        if (rspValid) rsp_cnt <= rsp_cnt + 1;
        cs_prev <= cs;
    end

    task automatic send(input cmd_kind_t k, input logic [2:0] r, input logic [16:0] a, input logic [7:0] d);
        int t = 0;
        @(negedge clock);
        while (!cmdReady && t < 100) begin
            @(negedge clock);
            t++;
        end
        n_cmp++;
        if (cmdReady !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: cmdReady=%b required 1", cmdReady);
        end
        cmdKind = k;
        cmdRegister = r;
        cmdAddress = a;
        cmdData = d;
        cmdValid = 1'b1;
        @(posedge clock);
        #1 cmdValid = 1'b0;
    endtask

    task automatic wait_idle(output int nb);
        nb = 0;
        @(negedge clock);
        while (busy && nb < 200) begin
            nb++;
            @(negedge clock);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        frc = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({cmdReady, busy, cs, we, rs, rspValid, rspData} !== {1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b busy=%b cs=%b we=%b rs=%0d rv=%b rd=%h required 0 0 1 1 0 0 00",
                     cmdReady, busy, cs, we, rs, rspValid, rspData);
        end
        n_cmp++;
        if (mpuData !== 8'h5A) begin
            n_bad++;
            $display("FAIL reset_data_release: mpuData=%h required 5a", mpuData);
        end
        frc = 1'b0;
        @(posedge clock);
        #1 resetN = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (cmdReady !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_edge: cmdReady=%b required 0", cmdReady);
        end
        @(negedge clock);
        n_cmp++;
        if (cmdReady !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: cmdReady=%b required 1", cmdReady);
        end
    endtask

    task automatic test_reg_write();
        logic [0:5] e_cs = 6'b100111, e_we = 6'b000011, e_busy = 6'b111110;
        send(CMD_REG_WRITE, 3'd5, 17'd0, 8'hA5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            n_cmp++;
            if ({cs, we, busy} !== {e_cs[k-1], e_we[k-1], e_busy[k-1]}) begin
                n_bad++;
                $display("FAIL wr_timing k=%0d: cs/we/busy=%b%b%b required %b%b%b",
                         k, cs, we, busy, e_cs[k-1], e_we[k-1], e_busy[k-1]);
            end
            if (k <= 4) begin
                n_cmp++;
                if ({rs, mpuData} !== {3'd5, 8'hA5}) begin
                    n_bad++;
                    $display("FAIL wr_stable k=%0d: rs=%0d data=%h required 5 a5", k, rs, mpuData);
                end
            end
        end
    endtask

    task automatic test_reg_read();
        logic [0:5] e_cs = 6'b100111, e_rv = 6'b000100;
        send(CMD_REG_READ, 3'd3, 17'd0, 8'h81);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            n_cmp++;
            if ({cs, we, rspValid} !== {e_cs[k-1], 1'b1, e_rv[k-1]}) begin
                n_bad++;
                $display("FAIL rd_timing k=%0d: cs/we/rv=%b%b%b required %b1%b",
                         k, cs, we, rspValid, e_cs[k-1], e_rv[k-1]);
            end
            if (!e_cs[k-1]) begin
                n_cmp++;
                if ({rs, mpuData} !== {3'd3, 8'h3C}) begin
                    n_bad++;
                    $display("FAIL rd_bus k=%0d: rs=%0d data=%h required 3 3c", k, rs, mpuData);
                end
            end
        end
        n_cmp++;
        if (rspData !== 8'h3C) begin
            n_bad++;
            $display("FAIL rd_data: rspData=%h required 3c", rspData);
        end
    endtask

    task automatic test_mem_write();
        logic [10:0] e[4] = '{{3'd0, 8'h45}, {3'd1, 8'h23}, {3'd2, 8'h01}, {3'd3, 8'h7E}};
        int nb, r0;
        wq.delete();
        r0 = rsp_cnt;
        send(CMD_MEM_WRITE, 3'd0, 17'h12345, 8'h7E);
        wait_idle(nb);
        n_cmp++;
        if (nb != 20 || rsp_cnt != r0) begin
            n_bad++;
            $display("FAIL mem_busy: busy_cycles=%0d rsp=%0d required 20 0", nb, rsp_cnt - r0);
        end
        n_cmp++;
        if (wq.size() != 4) begin
            n_bad++;
            $display("FAIL mem_count: writes=%0d required 4", wq.size());
        end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            n_cmp++;
            if (wq[i] !== e[i]) begin
                n_bad++;
                $display("FAIL mem_seq %0d: reg=%0d data=%h required reg=%0d data=%h",
                         i, wq[i][10:8], wq[i][7:0], e[i][10:8], e[i][7:0]);
            end
        end
    endtask

    task automatic test_addr_sequence();
        logic [10:0] e[$];
        int nb;
`ifdef MPU_MASTER_ADDR_CACHE_EN
        e = '{{3'd3, 8'h11},
              {3'd0, 8'hFF}, {3'd1, 8'hFF}, {3'd3, 8'h22},
              {3'd3, 8'h33}};
`else
        e = '{{3'd0, 8'h46}, {3'd1, 8'h23}, {3'd2, 8'h01}, {3'd3, 8'h11},
              {3'd0, 8'hFF}, {3'd1, 8'hFF}, {3'd2, 8'h01}, {3'd3, 8'h22},
              {3'd0, 8'h00}, {3'd1, 8'h00}, {3'd2, 8'h00}, {3'd3, 8'h33}};
`endif
        e.push_back({3'd1, 8'h44});
        e.push_back({3'd0, 8'h01});
        e.push_back({3'd1, 8'h00});
        e.push_back({3'd2, 8'h00});
        e.push_back({3'd3, 8'h55});
        wq.delete();
        send(CMD_MEM_WRITE, 3'd0, 17'h12346, 8'h11);
        wait_idle(nb);
        send(CMD_MEM_WRITE, 3'd0, 17'h1FFFF, 8'h22);
        wait_idle(nb);
        send(CMD_MEM_WRITE, 3'd0, 17'h00000, 8'h33);
        wait_idle(nb);
        send(CMD_REG_WRITE, 3'd1, 17'd0, 8'h44);
        wait_idle(nb);
        send(CMD_RSVD, 3'd1, 17'd0, 8'h99);
        n_cmp++;
        if ({busy, cs} !== 2'b01) begin
            n_bad++;
            $display("FAIL rsvd_idle: busy=%b cs=%b required 0 1", busy, cs);
        end
        send(CMD_MEM_WRITE, 3'd0, 17'h00001, 8'h55);
        wait_idle(nb);
        n_cmp++;
        if (wq.size() != e.size()) begin
            n_bad++;
            $display("FAIL seq_count: writes=%0d required %0d", wq.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < wq.size(); i++) begin
            n_cmp++;
            if (wq[i] !== e[i]) begin
                n_bad++;
                $display("FAIL seq_write %0d: reg=%0d data=%h required reg=%0d data=%h",
                         i, wq[i][10:8], wq[i][7:0], e[i][10:8], e[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:9] e_busy = 10'b0111101111, e_cs = 10'b1100111001;
        @(negedge clock);
        cmdKind = CMD_REG_WRITE;
        cmdRegister = 3'd6;
        cmdData = 8'h0F;
        cmdValid2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clock);
            n_cmp++;
            if ({busy2, cmdReady2, cs2} !== {e_busy[k], !e_busy[k], e_cs[k]}) begin
                n_bad++;
                $display("FAIL b2b k=%0d: busy/rdy/cs=%b%b%b required %b%b%b",
                         k, busy2, cmdReady2, cs2, e_busy[k], !e_busy[k], e_cs[k]);
            end
        end
        cmdValid2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        send(CMD_REG_WRITE, 3'd5, 17'd0, 8'hA5);
        repeat (2) @(negedge clock);
        #1;
        resetN = 1'b0;
        frc = 1'b1;
        #1;
        n_cmp++;
        if ({cs, we, busy, cmdReady, mpuData} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h5A}) begin
            n_bad++;
            $display("FAIL reset_mid: cs=%b we=%b busy=%b rdy=%b data=%h required 1 1 0 0 5a",
                     cs, we, busy, cmdReady, mpuData);
        end
        @(posedge clock);
        #1;
        resetN = 1'b1;
        frc = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({cmdReady, busy, cs} !== 3'b101) begin
            n_bad++;
            $display("FAIL reset_mid_release: rdy=%b busy=%b cs=%b required 1 0 1", cmdReady, busy, cs);
        end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_reg_read();
        test_mem_write();
        test_addr_sequence();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
